ps2_scan_decoder: RTL

//  Consumes raw scan-code bytes from the PS/2 frame receiver and turns Set-2 byte sequences into key events.
//  - Strips E0 (extended) and F0 (break) prefixes; drops BAT and ack bytes.
//  - Holds the last pressed key as two hex nibbles that feed proj4_7seg4 (en7Seg, key_code1, key_code0).
//  - Raises a one-cycle key_strobe per event.
//  - Sits between ps2 and the 7-seg driver in top; runs entirely on clk100Mhz.

---
 rtl/ps2_scan_decoder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 Set-2 scan-code byte stream to key events.
// Optional typematic-repeat suppression is enabled with `define PS2_REPEAT_FILTER_EN.
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TIMEOUT_W      = 18
) (
  input  logic       clk100Mhz,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [3:0] key_code1,
  output logic [3:0] key_code0,
  output logic       en7Seg,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state, w_next;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [7:0]           r_code;
  logic                 r_en, r_ext, r_rel, r_strobe;

  logic w_is_e0, w_is_f0, w_is_drop, w_timeout;
  logic w_emit, w_ev_ext, w_ev_rel, w_fire;

  assign w_is_e0   = (byte_in == 8'hE0);
  assign w_is_f0   = (byte_in == 8'hF0);
  assign w_is_drop = (byte_in == 8'hAA) || (byte_in == 8'hFA) || (byte_in == 8'hFE) ||
                     (byte_in == 8'hEE) || (byte_in == 8'h00) || (byte_in == 8'hFF);
  // A byte arriving on the last counted cycle takes precedence over the timeout.
  assign w_timeout = (r_state != IDLE) && (r_cnt == TO_LAST) && !byte_valid;

  always_comb begin
    w_next   = r_state;
    w_emit   = 1'b0;
    w_ev_ext = 1'b0;
    w_ev_rel = 1'b0;
    if (byte_valid) begin
      case (r_state)
        IDLE: begin
          if (w_is_e0)        w_next = EXT;
          else if (w_is_f0)   w_next = BRK;
          else if (!w_is_drop) w_emit = 1'b1;
        end
        EXT: begin
          if (w_is_f0)        w_next = EXT_BRK;
          else if (w_is_e0)   w_next = EXT;
          else begin
            w_next   = IDLE;
            w_emit   = !w_is_drop;
            w_ev_ext = 1'b1;
          end
        end
        BRK: begin
          if (w_is_f0)        w_next = BRK;
          else if (w_is_e0)   w_next = EXT_BRK;
          else begin
            w_next   = IDLE;
            w_emit   = !w_is_drop;
            w_ev_rel = 1'b1;
          end
        end
        default: begin
          if (w_is_f0 || w_is_e0) w_next = EXT_BRK;
          else begin
            w_next   = IDLE;
            w_emit   = !w_is_drop;
            w_ev_ext = 1'b1;
            w_ev_rel = 1'b1;
          end
        end
      endcase
    end else if (w_timeout) begin
      w_next = IDLE;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] r_held;
  logic       r_held_valid;
  logic       w_match;

  assign w_match = r_held_valid && (r_held == {w_ev_ext, byte_in});
  assign w_fire  = w_emit && !(!w_ev_rel && w_match);

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      r_held       <= 9'd0;
      r_held_valid <= 1'b0;
    end else if (w_emit) begin
      if (!w_ev_rel && !w_match) begin
        r_held       <= {w_ev_ext, byte_in};
        r_held_valid <= 1'b1;
      end else if (w_ev_rel && w_match) begin
        r_held_valid <= 1'b0;
      end
    end
  end
`else
  assign w_fire = w_emit;
`endif

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (byte_valid || (r_state == IDLE) || w_timeout) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      r_code   <= 8'd0;
      r_en     <= 1'b0;
      r_ext    <= 1'b0;
      r_rel    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_fire;
      if (w_fire) begin
        r_ext <= w_ev_ext;
        r_rel <= w_ev_rel;
        // Breaks leave the code alone so the display keeps the last pressed key.
        if (!w_ev_rel) begin
          r_code <= byte_in;
          r_en   <= 1'b1;
        end
      end
    end
  end

  assign key_code1   = r_code[7:4];
  assign key_code0   = r_code[3:0];
  assign en7Seg      = r_en;
  assign key_ext     = r_ext;
  assign key_release = r_rel;
  assign key_strobe  = r_strobe;

endmodule
